cache_line_mover: RTL and testbench
===================================

// Module: cache_line_mover
// PURPOSE
//  Initiator side of the word-wide memory read/write port (addr/en/ready, rdata/rdata_valid).
//  Moves whole cache lines for the cache controller.
//  Optional dirty-line writeback, always followed by a line fill; filled line returned as one vector.
//  Sits between the cache controller and the memory controller's core-side port.
// PARAMETERS
//  mem_depth   32  memory depth in words; word address width AW=$clog2(mem_depth)
//  data_width  32  word width
//  line_words  4   words per line (power of 2, >=2); OW=$clog2(line_words), LAW=AW-OW
// PORTS
//  clk             in   1            clock
//  rst_n           in   1            async active-low reset
//  req_valid       in   1            line request
//  req_ready       out  1            1 only in IDLE; request accepted when req_valid&&req_ready
//  req_wb          in   1            write back req_wb_data before the fill
//  req_wb_line     in   LAW          writeback line address
//  req_wb_data     in   line_words*DW  writeback line, word i at bits [i*DW +: DW]
//  req_fill_line   in   LAW          fill line address
//  req_word_off    in   OW           critical word offset (used only with CWF macro)
//  fill_data       out  line_words*DW  filled line; stable from done until next accept
//  done            out  1            1-cycle pulse, line fill complete
//  crit_valid      out  1            1-cycle pulse, critical word captured (CWF only, else 0)
//  crit_data       out  DW           critical word (CWF only, else 0)
//  mem_raddr/mem_ren/mem_rready(in)/mem_rdata(in)/mem_rdata_valid(in)   read port
//  mem_waddr/mem_wen/mem_wready(in)/mem_wdata                           write port
// BEHAVIOUR
//  Reset values: mem_ren=0, mem_wen=0, addrs/wdata=0, done=0, crit_valid=0, fill_data=0, state IDLE.
//  States IDLE -> WB (req_wb) | RD ; WB -> RD ; RD -> DONE ; DONE -> IDLE.
//  Accept: latch both line addrs, wb data and offset; req_wb=0 goes straight to RD.
//  WB:
//   - mem_wen=1, mem_waddr={wb_line,wcnt}, mem_wdata=word wcnt.
//   - A word is taken when mem_wready=1; wcnt increments then.
//   - When word line_words-1 is taken, go to RD.
//  RD:
//   - mem_ren=1 while icnt<line_words, mem_raddr={fill_line,(icnt+off)}; the offset add wraps mod line_words.
//   - A read is accepted when mem_rready=1.
//   - Data arrives with mem_rdata_valid exactly 1 cycle after accept. It must be captured that cycle into slot (rcnt+off); rdata is not held.
//   - Issue and return counters are independent, so an accept and a return in the same cycle are both counted.
//   - When rcnt reaches line_words, go to DONE.
//  DONE: done=1 for one cycle, req_ready=0; IDLE next cycle.
//  A stall (ready=0) holds addr/data/en stable. A read is never issued before the last write is taken, so a fill of the same line returns the written data.
//  No-stall latency, 4-word line, no wb: mem_ren in cycles 1-4 after accept; done in cycle 6. With writeback add 4.
//  Reset mid-operation aborts immediately. Outputs go to reset values and the partial line is discarded.
// CONFIGURATION
//  CACHE_LINE_MOVER_CWF_EN defined: reads start at req_word_off and wrap to 0.
//   crit_valid pulses the cycle after the first return, with crit_data = that word.
//  Undefined: off treated as 0, reads ascend from word 0, crit_valid and crit_data tied 0.
// STRUCTURE
//  cache_pkg: mover_state_e enum (IDLE,WB,RD,DONE), LINE_WORDS/OW/LAW localparams,
//   helper function for {line,offset} address concatenation.
//  Sub-module cache_line_buf: line_words x data_width register with word write port and flat output.
//   Instantiated once for fill data; wb data held in the same-type buffer.
// TESTING
//  1 fill, no stalls, line 3 holds 0xA0..0xA3 -> raddr 12,13,14,15; fill_data={A3,A2,A1,A0}; done 6 cycles after accept.
//  2 wb line 2 = {D3..D0} + fill line 2 -> writes to addr 8..11 before any ren; fill returns D0..D3.
//  3 mem_rready=0 for 3 cycles mid-fill -> raddr/ren held; each returned word captured once; done delayed 3 cycles.
//  4 CWF_EN, off=2, line 1 -> raddr order 6,7,4,5; crit_valid once with mem[6]; fill_data in natural slot order.
//  5 rst_n low while in WB after 2 words -> mem_wen=0 asynchronously; after release req_ready=1 and no further write.
//  6 back-to-back requests held valid -> second accepted the cycle after done; fill_data of first stable until then.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and defaults for the cache line mover and its line buffer.
package cache_pkg;

  localparam int unsigned MEM_DEPTH  = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned AW         = $clog2(MEM_DEPTH);
  localparam int unsigned OW         = $clog2(LINE_WORDS);
  localparam int unsigned LAW        = AW - OW;

  typedef logic [LAW-1:0] line_addr_t;

  typedef enum logic [1:0] {IDLE, WB, RD, DONE} mover_state_e;

  // Word address of word off within line number line, for a line of 2**ow words.
  function automatic logic [31:0] line_addr(input logic [31:0] line, input logic [31:0] off,
                                            input int unsigned ow);
    return (line << ow) | off;
  endfunction

endpackage

// File: rtl/cache_line_buf.sv
// One cache line of registers: whole-line load, single-word write, flat readout.
module cache_line_buf
  import cache_pkg::*;
#(
  parameter int unsigned line_words = LINE_WORDS,
  parameter int unsigned data_width = DATA_WIDTH,
  localparam int unsigned IW = $clog2(line_words)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             ld,
  input  logic [line_words*data_width-1:0] ld_data,
  input  logic                             we,
  input  logic [IW-1:0]                    widx,
  input  logic [data_width-1:0]            wdata,
  output logic [line_words*data_width-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (ld) begin
      q <= ld_data;
    end else if (we) begin
      q[widx*data_width +: data_width] <= wdata;
    end
  end

endmodule

// File: rtl/cache_line_mover.sv
// Moves whole cache lines over the word-wide memory port: optional writeback, then fill.
// Define CACHE_LINE_MOVER_CWF_EN for critical-word-first fills.
module cache_line_mover
  import cache_pkg::*;
#(
  parameter int unsigned mem_depth  = MEM_DEPTH,
  parameter int unsigned data_width = DATA_WIDTH,
  parameter int unsigned line_words = LINE_WORDS,
  localparam int unsigned ADDR_W  = $clog2(mem_depth),
  localparam int unsigned OFF_W   = $clog2(line_words),
  localparam int unsigned LINE_AW = ADDR_W - OFF_W,
  localparam int unsigned DW      = data_width
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_wb,
  input  logic [LINE_AW-1:0]       req_wb_line,
  input  logic [line_words*DW-1:0] req_wb_data,
  input  logic [LINE_AW-1:0]       req_fill_line,
  input  logic [OFF_W-1:0]         req_word_off,
  output logic [line_words*DW-1:0] fill_data,
  output logic                     done,
  output logic                     crit_valid,
  output logic [DW-1:0]            crit_data,
  output logic [ADDR_W-1:0]        mem_raddr,
  output logic                     mem_ren,
  input  logic                     mem_rready,
  input  logic [DW-1:0]            mem_rdata,
  input  logic                     mem_rdata_valid,
  output logic [ADDR_W-1:0]        mem_waddr,
  output logic                     mem_wen,
  input  logic                     mem_wready,
  output logic [DW-1:0]            mem_wdata
);

  mover_state_e           state;
  logic [OFF_W:0]         icnt, rcnt;
  logic [OFF_W-1:0]       wcnt, wnext, rnext, slot, off, off_in;
  logic [LINE_AW-1:0]     wb_line, fill_line;
  logic [line_words*DW-1:0] wb_flat;
  logic                   accept, fill_we;

  assign accept = (state == IDLE) && req_valid;

  always_comb begin
    wnext   = wcnt + 1'b1;
    rnext   = OFF_W'(icnt + 1'b1) + off;
    slot    = OFF_W'(rcnt) + off;
    fill_we = (state == RD) && mem_rdata_valid;
  end

`ifdef CACHE_LINE_MOVER_CWF_EN
  assign off_in = req_word_off;

  // First returned word is the critical one; report it the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off        <= '0;
      crit_valid <= 1'b0;
      crit_data  <= '0;
    end else begin
      crit_valid <= 1'b0;
      if (accept) off <= req_word_off;
      if (fill_we && rcnt == '0) begin
        crit_valid <= 1'b1;
        crit_data  <= mem_rdata;
      end
    end
  end
`else
  logic unused_off;
  assign unused_off = ^req_word_off;
  assign off_in     = '0;
  assign off        = '0;
  assign crit_valid = 1'b0;
  assign crit_data  = '0;
`endif

  cache_line_buf #(.line_words(line_words), .data_width(DW)) u_wb_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld      (accept),
    .ld_data (req_wb_data),
    .we      (1'b0),
    .widx    ('0),
    .wdata   ('0),
    .q       (wb_flat)
  );

  cache_line_buf #(.line_words(line_words), .data_width(DW)) u_fill_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld      (1'b0),
    .ld_data ('0),
    .we      (fill_we),
    .widx    (slot),
    .wdata   (mem_rdata),
    .q       (fill_data)
  );

  // Issue and return counters advance independently in RD; reads start only after the last write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      done      <= 1'b0;
      mem_ren   <= 1'b0;
      mem_raddr <= '0;
      mem_wen   <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      icnt      <= '0;
      rcnt      <= '0;
      wcnt      <= '0;
      wb_line   <= '0;
      fill_line <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            wb_line   <= req_wb_line;
            fill_line <= req_fill_line;
            icnt      <= '0;
            rcnt      <= '0;
            wcnt      <= '0;
            if (req_wb) begin
              state     <= WB;
              mem_wen   <= 1'b1;
              mem_waddr <= ADDR_W'(line_addr(32'(req_wb_line), 32'd0, OFF_W));
              mem_wdata <= req_wb_data[DW-1:0];
            end else begin
              state     <= RD;
              mem_ren   <= 1'b1;
              mem_raddr <= ADDR_W'(line_addr(32'(req_fill_line), 32'(off_in), OFF_W));
            end
          end
        end
        WB: begin
          if (mem_wready) begin
            wcnt <= wnext;
            if (wcnt == OFF_W'(line_words - 1)) begin
              state     <= RD;
              mem_wen   <= 1'b0;
              mem_ren   <= 1'b1;
              mem_raddr <= ADDR_W'(line_addr(32'(fill_line), 32'(off), OFF_W));
            end else begin
              mem_waddr <= ADDR_W'(line_addr(32'(wb_line), 32'(wnext), OFF_W));
              mem_wdata <= wb_flat[wnext*DW +: DW];
            end
          end
        end
        RD: begin
          if (mem_ren && mem_rready) begin
            icnt <= icnt + 1'b1;
            if (icnt == (OFF_W+1)'(line_words - 1)) begin
              mem_ren <= 1'b0;
            end else begin
              mem_raddr <= ADDR_W'(line_addr(32'(fill_line), 32'(rnext), OFF_W));
            end
          end
          if (mem_rdata_valid) begin
            rcnt <= rcnt + 1'b1;
            if (rcnt == (OFF_W+1)'(line_words - 1)) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_mover.sv
// Scoreboard bench for cache_line_mover with a 1-cycle-latency memory model.
module tb_cache_line_mover;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready, req_wb;
  logic [2:0]   req_wb_line, req_fill_line;
  logic [127:0] req_wb_data, fill_data;
  logic [1:0]   req_word_off;
  logic         done, crit_valid;
  logic [31:0]  crit_data;
  logic [4:0]   mem_raddr, mem_waddr;
  logic         mem_ren, mem_rready, mem_rdata_valid, mem_wen, mem_wready;
  logic [31:0]  mem_rdata, mem_wdata;

  always #5 clk = ~clk;

  cache_line_mover dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wb(req_wb),
    .req_wb_line(req_wb_line), .req_wb_data(req_wb_data),
    .req_fill_line(req_fill_line), .req_word_off(req_word_off),
    .fill_data(fill_data), .done(done), .crit_valid(crit_valid), .crit_data(crit_data),
    .mem_raddr(mem_raddr), .mem_ren(mem_ren), .mem_rready(mem_rready),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
    .mem_waddr(mem_waddr), .mem_wen(mem_wen), .mem_wready(mem_wready), .mem_wdata(mem_wdata)
  );

`ifdef CACHE_LINE_MOVER_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [31:0]  mem [32];
  logic [31:0]  q_raddr[$], q_waddr[$], q_wdata[$], q_crit[$];
  logic [127:0] q_fill[$];
  int           q_lat[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read data valid exactly one cycle after an accepted read.
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hC000_0000 + 32'(i);
    for (int i = 0; i < 4; i++) mem[12+i] = 32'hA0 + 32'(i);
    mem_rdata_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      mem_rdata_valid <= mem_ren && mem_rready;
      if (mem_ren && mem_rready) mem_rdata <= mem[mem_raddr];
      if (mem_wen && mem_wready) mem[mem_waddr] <= mem_wdata;
    end
  end

  // Monitor: pops expected transactions as the DUT presents them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_valid && req_ready) acc_cyc = cyc;
      if (mem_wen && mem_wready) begin
        if (q_waddr.size() == 0) check("unexpected_write", mem_waddr, 5'h1f ^ mem_waddr);
        else begin
          check("waddr", mem_waddr, q_waddr.pop_front());
          check("wdata", mem_wdata, q_wdata.pop_front());
        end
      end
      if (mem_ren && mem_rready) begin
        check("read_before_wb_done", q_waddr.size(), 0);
        if (q_raddr.size() == 0) check("unexpected_read", mem_raddr, 5'h1f ^ mem_raddr);
        else check("raddr", mem_raddr, q_raddr.pop_front());
      end
      if (mem_ren && !mem_rready && q_raddr.size() != 0) check("raddr_hold", mem_raddr, q_raddr[0]);
      if (done) begin
        if (q_fill.size() == 0) check("unexpected_done", done, 1'b0);
        else begin
          check("fill_data", fill_data, q_fill.pop_front());
          check("latency", cyc - acc_cyc, q_lat.pop_front());
        end
      end
      if (crit_valid) begin
        if (q_crit.size() == 0) check("unexpected_crit", crit_valid, 1'b0);
        else check("crit_data", crit_data, q_crit.pop_front());
      end
    end
  end

  task automatic issue(input bit wb, input logic [2:0] wline, input logic [127:0] wdata,
                       input logic [2:0] fline, input logic [1:0] off);
    bit got = 1'b0;
    @(posedge clk); #1;
    req_wb = wb; req_wb_line = wline; req_wb_data = wdata;
    req_fill_line = fline; req_word_off = off; req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin got = 1'b1; break; end
    end
    check("accept_timeout", got, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    check("done_timeout", got, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2;
    bit got;
    rst_n = 1'b0; req_valid = 1'b0; req_wb = 1'b0; req_wb_line = '0; req_wb_data = '0;
    req_fill_line = '0; req_word_off = '0; mem_rready = 1'b1; mem_wready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_ren", mem_ren, 1'b0);
    check("rst_wen", mem_wen, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_crit", crit_valid, 1'b0);
    check("rst_fill", fill_data, 128'h0);
    check("rst_addrs", {mem_raddr, mem_waddr, mem_wdata}, 42'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: plain fill of line 3
    for (int i = 0; i < 4; i++) q_raddr.push_back(32'd12 + 32'(i));
    q_fill.push_back({32'hA3, 32'hA2, 32'hA1, 32'hA0}); q_lat.push_back(6);
    if (CWF) q_crit.push_back(32'hA0);
    issue(1'b0, 3'd0, 128'h0, 3'd3, 2'd0);
    wait_done();

    // 2: writeback line 2 then fill the same line
    for (int i = 0; i < 4; i++) begin
      q_waddr.push_back(32'd8 + 32'(i)); q_wdata.push_back(32'hD0 + 32'(i));
      q_raddr.push_back(32'd8 + 32'(i));
    end
    q_fill.push_back({32'hD3, 32'hD2, 32'hD1, 32'hD0}); q_lat.push_back(10);
    if (CWF) q_crit.push_back(32'hD0);
    issue(1'b1, 3'd2, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 3'd2, 2'd0);
    wait_done();

    // 3: read stall for 3 cycles after two reads of line 0
    for (int i = 0; i < 4; i++) q_raddr.push_back(32'(i));
    q_fill.push_back({32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000});
    q_lat.push_back(9);
    if (CWF) q_crit.push_back(32'hC000_0000);
    issue(1'b0, 3'd0, 128'h0, 3'd0, 2'd0);
    repeat (2) @(posedge clk); #1 mem_rready = 1'b0;
    repeat (3) @(posedge clk); #1 mem_rready = 1'b1;
    wait_done();

    // 4: word offset 2 on line 1 (honoured only with critical-word-first)
    if (CWF) begin
      q_raddr.push_back(32'd6); q_raddr.push_back(32'd7);
      q_raddr.push_back(32'd4); q_raddr.push_back(32'd5);
      q_crit.push_back(32'hC000_0006);
    end else begin
      for (int i = 0; i < 4; i++) q_raddr.push_back(32'd4 + 32'(i));
    end
    q_fill.push_back({32'hC000_0007, 32'hC000_0006, 32'hC000_0005, 32'hC000_0004});
    q_lat.push_back(6);
    issue(1'b0, 3'd0, 128'h0, 3'd1, 2'd2);
    wait_done();

    // 5: reset in the middle of a writeback to line 5
    q_waddr.push_back(32'd20); q_wdata.push_back(32'hE0);
    q_waddr.push_back(32'd21); q_wdata.push_back(32'hE1);
    issue(1'b1, 3'd5, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 3'd5, 2'd0);
    repeat (2) @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("abort_wen", mem_wen, 1'b0);
    check("abort_done", done, 1'b0);
    repeat (2) @(posedge clk); #3 rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready", req_ready, 1'b1);
    repeat (10) @(posedge clk);
    check("abort_mem22", mem[22], 32'hC000_0016);
    check("abort_mem21", mem[21], 32'hE1);
    #1;

    // 6: back-to-back requests, line 3 then line 0
    for (int i = 0; i < 4; i++) q_raddr.push_back(32'd12 + 32'(i));
    for (int i = 0; i < 4; i++) q_raddr.push_back(32'(i));
    q_fill.push_back({32'hA3, 32'hA2, 32'hA1, 32'hA0}); q_lat.push_back(6);
    q_fill.push_back({32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000});
    q_lat.push_back(6);
    if (CWF) begin q_crit.push_back(32'hA0); q_crit.push_back(32'hC000_0000); end
    @(posedge clk); #1;
    req_wb = 1'b0; req_fill_line = 3'd3; req_word_off = '0; req_valid = 1'b1;
    c1 = 0; got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin got = 1'b1; c1 = cyc; break; end
    end
    check("b2b_first_accept", got, 1'b1);
    @(posedge clk); #1 req_fill_line = 3'd0;
    c2 = 0; got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin got = 1'b1; c2 = cyc; break; end
    end
    check("b2b_second_accept", got, 1'b1);
    check("b2b_gap", c2 - c1, 7);
    check("b2b_fill_hold", fill_data, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    @(posedge clk); #1 req_valid = 1'b0;
    wait_done();

    repeat (3) @(posedge clk);
    check("queues_empty",
          q_raddr.size() + q_waddr.size() + q_fill.size() + q_lat.size() + q_crit.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
